mat_loader: RTL and testbench

- Upstream feeder for the matrix multiplier stage.
- Accepts a stream of matrix elements over a valid/ready handshake and fills operand buffers A and B in row-major order.
- Issues a one-cycle start pulse once both are full, then holds both operands stable until the multiplier reports done.
- Sits between the accelerator's bus-side register interface and the multiplier.

---
 rtl/mat_acc_pkg.sv | 25 ++
 rtl/mat_buf.sv | 47 ++++
 rtl/mat_loader.sv | 108 ++++++++++
 tb/tb_mat_loader.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_acc_pkg.sv
// Shared types and helpers for the matrix accelerator operand path.
package mat_acc_pkg;

  localparam int MAT_SIZE = 2;
  localparam int DAT_SIZE = 8;

  typedef logic [DAT_SIZE-1:0] elem_t;
  typedef elem_t mat_t [MAT_SIZE][MAT_SIZE];

  typedef enum logic [1:0] {LOAD, START, WAIT_DONE} state_t;

  typedef struct packed {
    logic [31:0] row;
    logic [31:0] col;
  } rc_t;

  // Row-major element index to (row, column) for an n x n matrix.
  function automatic rc_t idx2rc(input int unsigned k, input int unsigned n);
    rc_t rc;
    rc.row = k / n;
    rc.col = k % n;
    return rc;
  endfunction

endpackage

// File: rtl/mat_buf.sv
// One operand buffer: row-major fill at the current count, full/last flags,
// count clear. Writes to a full buffer are dropped by the buffer itself.
module mat_buf
  import mat_acc_pkg::*;
#(
  parameter int mat_size = MAT_SIZE,
  parameter int dat_size = DAT_SIZE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic                clr,
  input  logic [dat_size-1:0] wdata,
  output logic [dat_size-1:0] mat [mat_size][mat_size],
  output logic                full,
  output logic                last
);

  localparam int N  = mat_size * mat_size;
  localparam int CW = $clog2(N) + 1;

  logic [CW-1:0] cnt;
  logic          wr;

  assign full = (cnt == CW'(N));
  assign last = (cnt == CW'(N - 1));
  assign wr   = we & ~clr & ~full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (wr)  cnt <= cnt + CW'(1);
  end

  for (genvar k = 0; k < N; k++) begin : g_elem
    localparam rc_t RC = idx2rc(k, mat_size);
    logic [dat_size-1:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    q <= '0;
      else if (wr && cnt == CW'(k))  q <= wdata;
    end

    assign mat[RC.row][RC.col] = q;
  end

endmodule

// File: rtl/mat_loader.sv
// Operand loader for the matrix multiplier: fills A/B, pulses start, holds
// operands until mult_done. Optional sticky overflow flag: MAT_LOADER_OVF_EN.
module mat_loader
  import mat_acc_pkg::*;
#(
  parameter int mat_size = MAT_SIZE,
  parameter int dat_size = DAT_SIZE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sel,
  input  logic [dat_size-1:0] in_data,
  input  logic                clear,
  output logic [dat_size-1:0] mat_A [mat_size][mat_size],
  output logic [dat_size-1:0] mat_B [mat_size][mat_size],
  output logic                start,
  input  logic                mult_done,
  output logic                busy,
  output logic                ovf
);

  state_t state_q, state_d;
  logic   we_a, we_b, buf_clr;
  logic   full_a, full_b, last_a, last_b;
  logic   go_start;

  // Clear beats a simultaneous element; in_ready is only high in LOAD.
  assign we_a = in_valid & in_ready & ~in_sel & ~clear;
  assign we_b = in_valid & in_ready &  in_sel & ~clear;

  // Look ahead so start follows the edge that completes the second buffer.
  assign go_start = ~clear & (full_a | (last_a & we_a))
                           & (full_b | (last_b & we_b));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    start    = 1'b0;
    busy     = 1'b0;
    buf_clr  = 1'b0;
    unique case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (clear)         buf_clr = 1'b1;
        else if (go_start) state_d = START;
      end
      START: begin
        start   = 1'b1;
        busy    = 1'b1;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        busy = 1'b1;
        if (mult_done) begin
          buf_clr = 1'b1;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  mat_buf #(.mat_size(mat_size), .dat_size(dat_size)) u_buf_a (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_a),
    .clr   (buf_clr),
    .wdata (in_data),
    .mat   (mat_A),
    .full  (full_a),
    .last  (last_a)
  );

  mat_buf #(.mat_size(mat_size), .dat_size(dat_size)) u_buf_b (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_b),
    .clr   (buf_clr),
    .wdata (in_data),
    .mat   (mat_B),
    .full  (full_b),
    .last  (last_b)
  );

`ifdef MAT_LOADER_OVF_EN
  logic drop, ovf_q;

  assign drop = (we_a & full_a) | (we_b & full_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf_q <= 1'b0;
    else if (buf_clr && state_q == LOAD) ovf_q <= 1'b0;
    else if (drop)    ovf_q <= 1'b1;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mat_loader.sv
// Scoreboard bench for mat_loader: expected operands queued per load, checked on start.
module tb_mat_loader;

  localparam int MS = 2;
  localparam int DS = 8;
`ifdef MAT_LOADER_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, in_sel, clear, start, mult_done, busy, ovf;
  logic [DS-1:0] in_data;
  logic [DS-1:0] mat_A [MS][MS];
  logic [DS-1:0] mat_B [MS][MS];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   start_cnt = 0;

  always #5 clk = ~clk;

  mat_loader #(.mat_size(MS), .dat_size(DS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .clear     (clear),
    .mat_A     (mat_A),
    .mat_B     (mat_B),
    .start     (start),
    .mult_done (mult_done),
    .busy      (busy),
    .ovf       (ovf)
  );

  // Scoreboard: every start pulse must match the oldest queued load.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && start === 1'b1) begin
      start_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL start_unexpected: got start=1, required no start (nothing queued)");
      end else begin
        e = exp_q.pop_front();
        for (int r = 0; r < MS; r++)
          for (int c = 0; c < MS; c++) begin
            checks += 2;
            if (mat_A[r][c] !== e.a[(r*MS+c)*8 +: 8]) begin
              errors++;
              $display("FAIL sb_mat_A[%0d][%0d]: got %h, required %h", r, c, mat_A[r][c], e.a[(r*MS+c)*8 +: 8]);
            end
            if (mat_B[r][c] !== e.b[(r*MS+c)*8 +: 8]) begin
              errors++;
              $display("FAIL sb_mat_B[%0d][%0d]: got %h, required %h", r, c, mat_B[r][c], e.b[(r*MS+c)*8 +: 8]);
            end
          end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_sel   = 1'b0;
    in_data  = '0;
  endtask

  task automatic send(input logic sel, input logic [7:0] d);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    tick();
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    exp_t x;
    x.a = a;
    x.b = b;
    exp_q.push_back(x);
  endtask

  task automatic done_pulse();
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); clear = 1'b0; mult_done = 1'b0;
    repeat (2) tick();
    checks += 4;
    if (start !== 1'b0)   begin errors++; $display("FAIL reset_start: got %b, required 0", start); end
    if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (ovf !== 1'b0)     begin errors++; $display("FAIL reset_ovf: got %b, required 0", ovf); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    for (int r = 0; r < MS; r++)
      for (int c = 0; c < MS; c++) begin
        checks++;
        if (mat_A[r][c] !== 8'h00 || mat_B[r][c] !== 8'h00) begin
          errors++;
          $display("FAIL reset_mat[%0d][%0d]: got A=%h B=%h, required 00", r, c, mat_A[r][c], mat_B[r][c]);
        end
      end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    push({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5});
    for (int k = 1; k <= 4; k++) send(1'b0, 8'(k));
    for (int k = 5; k <= 7; k++) send(1'b1, 8'(k));
    checks++;
    if (start !== 1'b0) begin errors++; $display("FAIL basic_early_start: got %b, required 0", start); end
    send(1'b1, 8'd8);
    idle();
    checks += 3;
    if (start !== 1'b1)    begin errors++; $display("FAIL basic_start: got %b, required 1", start); end
    if (busy !== 1'b1)     begin errors++; $display("FAIL basic_busy: got %b, required 1", busy); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready: got %b, required 0", in_ready); end
    tick();
    checks += 2;
    if (start !== 1'b0) begin errors++; $display("FAIL basic_start_width: got %b, required 0", start); end
    if (busy !== 1'b1)  begin errors++; $display("FAIL basic_busy_wait: got %b, required 1", busy); end
    done_pulse();
    checks += 2;
    if (busy !== 1'b0)     begin errors++; $display("FAIL basic_done_busy: got %b, required 0", busy); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_done_ready: got %b, required 1", in_ready); end
  endtask

  task automatic test_interleaved();
    push({8'd14, 8'd13, 8'd12, 8'd11}, {8'd18, 8'd17, 8'd16, 8'd15});
    for (int k = 0; k < 4; k++) begin
      send(1'b0, 8'(11 + k));
      if (k == 3) begin
        checks++;
        if (start !== 1'b0) begin errors++; $display("FAIL inter_early_start: got %b, required 0", start); end
      end
      send(1'b1, 8'(15 + k));
    end
    idle();
    checks++;
    if (start !== 1'b1) begin errors++; $display("FAIL inter_start: got %b, required 1", start); end
    tick();
    done_pulse();
  endtask

  task automatic test_overflow();
    push({8'd24, 8'd23, 8'd22, 8'd21}, {8'd28, 8'd27, 8'd26, 8'd25});
    for (int k = 0; k < 4; k++) send(1'b0, 8'(21 + k));
    send(1'b0, 8'h99);
    idle();
    checks += 2;
    if (ovf !== OVF_EXP) begin errors++; $display("FAIL ovf_set: got %b, required %b", ovf, OVF_EXP); end
    if (start !== 1'b0)  begin errors++; $display("FAIL ovf_no_start: got %b, required 0", start); end
    for (int k = 0; k < 4; k++) send(1'b1, 8'(25 + k));
    idle();
    checks++;
    if (start !== 1'b1) begin errors++; $display("FAIL ovf_start: got %b, required 1", start); end
    tick();
    done_pulse();
    checks++;
    if (ovf !== OVF_EXP) begin errors++; $display("FAIL ovf_sticky: got %b, required %b", ovf, OVF_EXP); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b, required 0", ovf); end
  endtask

  task automatic test_hold();
    push({8'd34, 8'd33, 8'd32, 8'd31}, {8'd38, 8'd37, 8'd36, 8'd35});
    for (int k = 0; k < 4; k++) send(1'b0, 8'(31 + k));
    for (int k = 0; k < 4; k++) send(1'b1, 8'(35 + k));
    idle();
    tick();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'hFF; in_sel = i[0];
      tick();
      checks += 2;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready: got %b, required 0", in_ready); end
      if (busy !== 1'b1)     begin errors++; $display("FAIL hold_busy: got %b, required 1", busy); end
    end
    idle();
    for (int r = 0; r < MS; r++)
      for (int c = 0; c < MS; c++) begin
        checks++;
        if (mat_A[r][c] !== 8'(31 + r*MS + c) || mat_B[r][c] !== 8'(35 + r*MS + c)) begin
          errors++;
          $display("FAIL hold_mat[%0d][%0d]: got A=%h B=%h, required A=%h B=%h", r, c,
                   mat_A[r][c], mat_B[r][c], 8'(31 + r*MS + c), 8'(35 + r*MS + c));
        end
      end
    // mult_done held high across the return to LOAD
    mult_done = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks += 2;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_done_ready: got %b, required 1", in_ready); end
      if (busy !== 1'b0)     begin errors++; $display("FAIL hold_done_busy: got %b, required 0", busy); end
    end
    mult_done = 1'b0;
    checks++;
    if (mat_A[0][0] !== 8'd31) begin errors++; $display("FAIL hold_retain: got %h, required 1f", mat_A[0][0]); end
  endtask

  task automatic test_clear();
    int sc;
    push({8'd44, 8'd43, 8'd42, 8'd41}, {8'd48, 8'd47, 8'd46, 8'd45});
    sc = start_cnt;
    for (int k = 0; k < 3; k++) send(1'b0, 8'(61 + k));
    clear = 1'b1;
    send(1'b0, 8'h55);
    clear = 1'b0;
    for (int k = 0; k < 4; k++) send(1'b0, 8'(41 + k));
    for (int k = 0; k < 3; k++) send(1'b1, 8'(45 + k));
    checks++;
    if (start !== 1'b0) begin errors++; $display("FAIL clear_early_start: got %b, required 0", start); end
    send(1'b1, 8'd48);
    idle();
    checks++;
    if (start !== 1'b1) begin errors++; $display("FAIL clear_start: got %b, required 1", start); end
    tick();
    checks++;
    if (start_cnt !== sc + 1) begin errors++; $display("FAIL clear_start_count: got %0d, required %0d", start_cnt, sc + 1); end
    done_pulse();
  endtask

  task automatic test_async_reset();
    int sc;
    push({8'd54, 8'd53, 8'd52, 8'd51}, {8'd58, 8'd57, 8'd56, 8'd55});
    for (int k = 0; k < 4; k++) send(1'b0, 8'(51 + k));
    for (int k = 0; k < 4; k++) send(1'b1, 8'(55 + k));
    idle();
    tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL arst_busy_before: got %b, required 1", busy); end
    #3 rst_n = 1'b0;
    #1;
    checks += 3;
    if (busy !== 1'b0)  begin errors++; $display("FAIL arst_busy: got %b, required 0", busy); end
    if (start !== 1'b0) begin errors++; $display("FAIL arst_start: got %b, required 0", start); end
    if (ovf !== 1'b0)   begin errors++; $display("FAIL arst_ovf: got %b, required 0", ovf); end
    for (int r = 0; r < MS; r++)
      for (int c = 0; c < MS; c++) begin
        checks++;
        if (mat_A[r][c] !== 8'h00 || mat_B[r][c] !== 8'h00) begin
          errors++;
          $display("FAIL arst_mat[%0d][%0d]: got A=%h B=%h, required 00", r, c, mat_A[r][c], mat_B[r][c]);
        end
      end
    sc = start_cnt;
    tick();
    rst_n = 1'b1;
    mult_done = 1'b1;
    repeat (4) tick();
    mult_done = 1'b0;
    checks += 2;
    if (start_cnt !== sc) begin errors++; $display("FAIL arst_no_start: got %0d starts, required %0d", start_cnt, sc); end
    if (busy !== 1'b0)    begin errors++; $display("FAIL arst_busy_after: got %b, required 0", busy); end
    push({8'd74, 8'd73, 8'd72, 8'd71}, {8'd78, 8'd77, 8'd76, 8'd75});
    for (int k = 0; k < 4; k++) send(1'b0, 8'(71 + k));
    for (int k = 0; k < 4; k++) send(1'b1, 8'(75 + k));
    idle();
    checks++;
    if (start !== 1'b1) begin errors++; $display("FAIL arst_reload_start: got %b, required 1", start); end
    tick();
    done_pulse();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_interleaved();
    test_overflow();
    test_hold();
    test_clear();
    test_async_reset();
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending loads, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
